mix_seq_ctrl: RTL and testbench
===============================

Name: mix_seq_ctrl

Overview:
- Sequencer for the shared mix layer datapath (mix_forward).
- Runs one HID_DIM-wide token vector through 1 to 3 consecutive mix layers (`F_MIX1 -> `F_MIX2 -> `F_MIX3).
- Drives run/state and holds the input vector stable for each layer; captures each layer's result and feeds it back as the next layer's input.
- Sits between the top-level train FSM (start/done handshake) and the mix_forward instance.

Parameters:
- HID_DIM, `HID_DIM, vector length in elements.
- N_LEN, `N_LEN, bits per element.
- STATE_LEN, `STATE_LEN, width of the state code driven to the datapath.
- TIMEOUT, 255, max RUN cycles per layer before abort (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin sequence; sampled only in IDLE.
- abort  in  1  synchronous cancel; returns to IDLE, no done.
- layer_num  in  2  layers to run, 1..3; 0 treated as 3; latched on accepted start.
- d_in  in  HID_DIM*N_LEN  input vector; latched on accepted start.
- busy  out  1  high from accepted start until done/abort/err.
- done  out  1  one-cycle pulse; q_out valid from this cycle on.
- err  out  1  one-cycle pulse on timeout; constant 0 without the feature.
- q_out  out  HID_DIM*N_LEN  final result; held until next done.
- mix_run  out  1  to mix_forward.run.
- mix_state  out  STATE_LEN  to mix_forward.state.
- mix_d  out  HID_DIM*N_LEN  to mix_forward.d; driven from the internal data register.
- mix_valid  in  1  from mix_forward.valid.
- mix_q  in  HID_DIM*N_LEN  from mix_forward.q.

Behaviour:
- Clocking and reset: one clock domain. On async reset: FSM=IDLE, busy=0, done=0, err=0, mix_run=0, mix_state=`F_MIX1, data reg=0, q_out=0, layer index=0.
- All outputs are registered.
- States: IDLE, SETUP, RUN.
- IDLE:
  - mix_run=0, mix_state=`F_MIX1 (preloads datapath address bias).
  - start=1 and abort=0: data reg<=d_in, latch layer_num, layer index<=0, busy<=1, go SETUP.
- SETUP (exactly 1 cycle):
  - mix_run=0, mix_state=code of the current layer index (0:`F_MIX1, 1:`F_MIX2, 2:`F_MIX3).
  - Guarantees at least one run-low cycle so the datapath reloads its read-address biases.
  - Next state RUN.
- RUN:
  - mix_run=1, mix_state unchanged, mix_d stable.
  - Wait-cycle counter increments each cycle.
  - At the edge where mix_valid=1:
    - Not last layer: data reg<=mix_q, index+1, mix_run<=0, go SETUP.
    - Last layer: q_out<=mix_q, done<=1 for one cycle, busy<=0, mix_run<=0, go IDLE.
- Latency: V = cycles from mix_run rise to the first mix_valid high. Start-to-done = L*(1+V)+1 cycles, where L is the effective layer count.
- mix_valid outside RUN is ignored.
- start while busy is ignored.
- abort has priority over every event in every state, including simultaneous mix_valid and start: go IDLE, busy<=0, no done, q_out unchanged, mix_run<=0 on the next edge.
- done and err never assert together.
- Async reset mid-sequence returns immediately to reset values.
- The layer index never exceeds 2; the state code is never X.

Optional Feature:
- Macro MIX_SEQ_TIMEOUT_EN.
- Defined:
  - The RUN wait counter is compared against TIMEOUT.
  - If TIMEOUT cycles elapse in RUN without mix_valid: err pulses 1 cycle, busy<=0, mix_run<=0, go IDLE, q_out unchanged.
  - mix_valid in the same cycle as expiry wins (normal completion).
- Not defined: no timeout logic; err tied 0; the controller waits indefinitely.

Test Plan:
- Behavioural datapath model with V=5, result = d+1 per element; layer_num=3, d_in all 0x10 -> done at cycle 3*6+1=19 after start; q_out all 0x13; mix_state sequence F_MIX1, F_MIX2, F_MIX3; one run-low cycle between runs.
- layer_num=1 and layer_num=0 -> done after 7 and 19 cycles; only `F_MIX1 run, resp. all three run.
- abort asserted during the second RUN -> busy falls, mix_run=0 next cycle, no done, q_out keeps its previous value; a subsequent start runs normally.
- start pulsed while busy; mix_valid pulsed during IDLE/SETUP -> no effect, result identical to the first scenario.
- Reset asserted mid-RUN -> all outputs at reset values immediately.
- With MIX_SEQ_TIMEOUT_EN, TIMEOUT=8, model never asserts valid -> err pulse on the 8th RUN cycle, busy=0; with valid on that same cycle -> normal completion, no err.

Source files
------------

// File: rtl/mix_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mix_seq_ctrl
//
// Sequencer for the shared mix layer datapath (mix_forward). It runs one
// HID_DIM-wide token vector through 1..3 consecutive mix layers
// (F_MIX1 -> F_MIX2 -> F_MIX3). For each layer it holds the operand vector
// stable, pulses the datapath through one run-low SETUP cycle followed by a
// RUN phase, and feeds each layer's result back as the next layer's input.
//
// Optional feature: define MIX_SEQ_TIMEOUT_EN to abort a layer that has not
// produced mix_valid within TIMEOUT RUN cycles (err pulse). Without the
// macro, err is tied low and the controller waits indefinitely.
//
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a sequence (sampled only in IDLE)
//   abort      in   synchronous cancel, highest priority, no done
//   layer_num  in   layers to run 1..3 (0 means 3), latched on start
//   d_in       in   input vector, latched on start
//   busy       out  high from accepted start until done/abort/err
//   done       out  one-cycle pulse, q_out valid from this cycle on
//   err        out  one-cycle timeout pulse (0 without the feature)
//   q_out      out  final result, held until the next done
//   mix_run    out  run strobe to mix_forward
//   mix_state  out  layer state code to mix_forward
//   mix_d      out  operand vector to mix_forward
//   mix_valid  in   result valid from mix_forward
//   mix_q      in   result vector from mix_forward
// -----------------------------------------------------------------------------
`ifndef HID_DIM
`define HID_DIM 4
`endif
`ifndef N_LEN
`define N_LEN 8
`endif
`ifndef STATE_LEN
`define STATE_LEN 4
`endif
`ifndef F_MIX1
`define F_MIX1 4'd5
`endif
`ifndef F_MIX2
`define F_MIX2 4'd6
`endif
`ifndef F_MIX3
`define F_MIX3 4'd7
`endif

module mix_seq_ctrl #(
    parameter int HID_DIM   = `HID_DIM,
    parameter int N_LEN     = `N_LEN,
    parameter int STATE_LEN = `STATE_LEN,
    parameter int TIMEOUT   = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic [1:0]                 layer_num,
    input  logic [HID_DIM*N_LEN-1:0]   d_in,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [HID_DIM*N_LEN-1:0]   q_out,
    output logic                       mix_run,
    output logic [STATE_LEN-1:0]       mix_state,
    output logic [HID_DIM*N_LEN-1:0]   mix_d,
    input  logic                       mix_valid,
    input  logic [HID_DIM*N_LEN-1:0]   mix_q
);

    localparam int VEC_W = HID_DIM * N_LEN;

    localparam logic [STATE_LEN-1:0] ST_MIX1 = STATE_LEN'(`F_MIX1);
    localparam logic [STATE_LEN-1:0] ST_MIX2 = STATE_LEN'(`F_MIX2);
    localparam logic [STATE_LEN-1:0] ST_MIX3 = STATE_LEN'(`F_MIX3);

    if (TIMEOUT < 1) begin : g_timeout_chk
        $error("mix_seq_ctrl: TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t            st;
    logic [VEC_W-1:0]  data_r;     // operand of the layer in flight
    logic [1:0]        idx;        // current layer index, 0..2
    logic [1:0]        last_idx;   // index of the final layer of this sequence

    // Layer index to datapath state code; anything past 1 maps to the last
    // layer so the code can never go undefined.
    function automatic logic [STATE_LEN-1:0] state_code(input logic [1:0] i);
        case (i)
            2'd0:    state_code = ST_MIX1;
            2'd1:    state_code = ST_MIX2;
            default: state_code = ST_MIX3;
        endcase
    endfunction

    assign mix_d = data_r;

`ifdef MIX_SEQ_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [CNT_W-1:0]  run_cnt;    // RUN cycles already completed without valid
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            mix_run   <= 1'b0;
            mix_state <= ST_MIX1;
            data_r    <= '0;
            q_out     <= '0;
            idx       <= 2'd0;
            last_idx  <= 2'd0;
`ifdef MIX_SEQ_TIMEOUT_EN
            err       <= 1'b0;
            run_cnt   <= '0;
`endif
        end else begin
            done <= 1'b0;
`ifdef MIX_SEQ_TIMEOUT_EN
            err  <= 1'b0;
`endif
            if (abort) begin
                // Cancel wins over start, mix_valid and timeout alike.
                st        <= S_IDLE;
                busy      <= 1'b0;
                mix_run   <= 1'b0;
                mix_state <= ST_MIX1;
            end else begin
                case (st)
                    S_IDLE: begin
                        if (start) begin
                            data_r    <= d_in;
                            last_idx  <= (layer_num == 2'd0) ? 2'd2 : (layer_num - 2'd1);
                            idx       <= 2'd0;
                            busy      <= 1'b1;
                            mix_state <= state_code(2'd0);
                            st        <= S_SETUP;
                        end
                    end

                    // One run-low cycle so the datapath reloads its read
                    // address biases for the new layer code.
                    S_SETUP: begin
                        mix_run <= 1'b1;
                        st      <= S_RUN;
`ifdef MIX_SEQ_TIMEOUT_EN
                        run_cnt <= '0;
`endif
                    end

                    S_RUN: begin
                        if (mix_valid) begin
                            mix_run <= 1'b0;
                            if (idx == last_idx) begin
                                q_out     <= mix_q;
                                done      <= 1'b1;
                                busy      <= 1'b0;
                                mix_state <= ST_MIX1;
                                st        <= S_IDLE;
                            end else begin
                                data_r    <= mix_q;
                                idx       <= idx + 2'd1;
                                mix_state <= state_code(idx + 2'd1);
                                st        <= S_SETUP;
                            end
                        end
`ifdef MIX_SEQ_TIMEOUT_EN
                        else if (run_cnt == CNT_W'(TIMEOUT - 1)) begin
                            err       <= 1'b1;
                            busy      <= 1'b0;
                            mix_run   <= 1'b0;
                            mix_state <= ST_MIX1;
                            st        <= S_IDLE;
                        end else begin
                            run_cnt <= run_cnt + CNT_W'(1);
                        end
`endif
                    end

                    default: begin
                        st        <= S_IDLE;
                        busy      <= 1'b0;
                        mix_run   <= 1'b0;
                        mix_state <= ST_MIX1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mix_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mix_seq_ctrl
//
// Directed bench for mix_seq_ctrl. A behavioural mix_forward model raises
// valid in the model_v-th cycle of a run and returns d+1 per element.
// -----------------------------------------------------------------------------
`ifndef HID_DIM
`define HID_DIM 4
`endif
`ifndef N_LEN
`define N_LEN 8
`endif
`ifndef STATE_LEN
`define STATE_LEN 4
`endif
`ifndef F_MIX1
`define F_MIX1 4'd5
`endif
`ifndef F_MIX2
`define F_MIX2 4'd6
`endif
`ifndef F_MIX3
`define F_MIX3 4'd7
`endif

module tb_mix_seq_ctrl;

    localparam int HID_DIM   = `HID_DIM;
    localparam int N_LEN     = `N_LEN;
    localparam int STATE_LEN = `STATE_LEN;
    localparam int VEC_W     = HID_DIM * N_LEN;

    localparam logic [STATE_LEN-1:0] ST_MIX1 = STATE_LEN'(`F_MIX1);
    localparam logic [STATE_LEN-1:0] ST_MIX2 = STATE_LEN'(`F_MIX2);
    localparam logic [STATE_LEN-1:0] ST_MIX3 = STATE_LEN'(`F_MIX3);

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic                 abort;
    logic [1:0]           layer_num;
    logic [VEC_W-1:0]     d_in;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic [VEC_W-1:0]     q_out;
    logic                 mix_run;
    logic [STATE_LEN-1:0] mix_state;
    logic [VEC_W-1:0]     mix_d;
    logic                 mix_valid;
    logic [VEC_W-1:0]     mix_q;

    int  n_tests = 0;
    int  n_fail  = 0;

    // datapath model controls
    int  model_v     = 5;
    bit  model_en    = 1'b1;
    bit  valid_force = 1'b0;
    int  mcnt;

    always #5 clk = ~clk;

    mix_seq_ctrl #(
        .HID_DIM  (HID_DIM),
        .N_LEN    (N_LEN),
        .STATE_LEN(STATE_LEN),
        .TIMEOUT  (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .layer_num(layer_num),
        .d_in     (d_in),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .q_out    (q_out),
        .mix_run  (mix_run),
        .mix_state(mix_state),
        .mix_d    (mix_d),
        .mix_valid(mix_valid),
        .mix_q    (mix_q)
    );

    always_ff @(posedge clk) begin
        if (!mix_run) mcnt <= 0;
        else          mcnt <= mcnt + 1;
    end

    assign mix_valid = valid_force | (model_en && mix_run && (mcnt == model_v - 1));

    always_comb begin
        mix_q = '0;
        for (int i = 0; i < HID_DIM; i++)
            mix_q[i*N_LEN +: N_LEN] = mix_d[i*N_LEN +: N_LEN] + N_LEN'(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one sequence and wait for done (bounded). lat counts edges from
    // the start edge to the first cycle with done visible.
    task automatic run_seq(input logic [1:0] ln, input logic [VEC_W-1:0] d, input bit inject,
                           output int lat, output int runs, output int errs,
                           output logic [STATE_LEN-1:0] s0, output logic [STATE_LEN-1:0] s1,
                           output logic [STATE_LEN-1:0] s2);
        logic prev_run;
        layer_num = ln;
        d_in      = d;
        start     = 1'b1;
        lat = 0; runs = 0; errs = 0;
        s0 = '0; s1 = '0; s2 = '0;
        prev_run = mix_run;
        while (lat < 200) begin
            tick();
            lat++;
            if (lat == 1) begin
                start = 1'b0;
                if (inject) begin
                    start       = 1'b1;
                    valid_force = 1'b1;
                    d_in        = '1;
                    layer_num   = 2'd1;
                end
            end else if (lat == 2) begin
                start       = 1'b0;
                valid_force = 1'b0;
            end
            if (mix_run && !prev_run) begin
                if (runs == 0) s0 = mix_state;
                else if (runs == 1) s1 = mix_state;
                else s2 = mix_state;
                runs++;
            end
            prev_run = mix_run;
            if (err) errs++;
            if (done) break;
        end
    endtask

    int lat, runs, errs, seen;
    logic [STATE_LEN-1:0] s0, s1, s2;

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; layer_num = 2'd0; d_in = '0;
        tick(); tick();
        check("rst_busy",  busy, 0);
        check("rst_done",  done, 0);
        check("rst_err",   err, 0);
        check("rst_run",   mix_run, 0);
        check("rst_state", mix_state, ST_MIX1);
        check("rst_q",     q_out, 0);
        check("rst_d",     mix_d, 0);
        rst_n = 1'b1;
        tick();

        // three layers
        run_seq(2'd3, 32'h10101010, 1'b0, lat, runs, errs, s0, s1, s2);
        check("l3_lat",  lat, 19);
        check("l3_q",    q_out, 32'h13131313);
        check("l3_runs", runs, 3);
        check("l3_s0",   s0, ST_MIX1);
        check("l3_s1",   s1, ST_MIX2);
        check("l3_s2",   s2, ST_MIX3);
        check("l3_err",  errs, 0);
        check("l3_busy", busy, 0);
        tick();
        check("l3_done_pulse", done, 0);
        check("l3_idle_state", mix_state, ST_MIX1);

        // single layer
        run_seq(2'd1, 32'h01020304, 1'b0, lat, runs, errs, s0, s1, s2);
        check("l1_lat",  lat, 7);
        check("l1_q",    q_out, 32'h02030405);
        check("l1_runs", runs, 1);
        check("l1_s0",   s0, ST_MIX1);
        tick();

        // layer_num 0 runs all three, elements wrap
        run_seq(2'd0, 32'hFEFF0010, 1'b0, lat, runs, errs, s0, s1, s2);
        check("l0_lat",  lat, 19);
        check("l0_q",    q_out, 32'h01020313);
        check("l0_runs", runs, 3);
        tick();

        // abort coinciding with mix_valid in the second run
        layer_num = 2'd3; d_in = 32'h20202020; start = 1'b1;
        tick();
        start = 1'b0;
        seen = 0; runs = 0;
        begin
            logic prev_run;
            prev_run = mix_run;
            for (int i = 0; i < 100; i++) begin
                if (mix_run && !prev_run) runs++;
                prev_run = mix_run;
                if (runs == 2 && mix_valid) break;
                tick();
            end
        end
        check("ab_reach_run2", runs, 2);
        check("ab_valid_seen", mix_valid, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_busy",  busy, 0);
        check("ab_run",   mix_run, 0);
        check("ab_done",  done, 0);
        check("ab_q",     q_out, 32'h01020313);
        check("ab_state", mix_state, ST_MIX1);
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done || busy) seen++;
        end
        check("ab_quiet", seen, 0);

        // abort beats start in IDLE
        start = 1'b1; abort = 1'b1; layer_num = 2'd1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("ab_start_busy", busy, 0);
        tick();

        // normal run after abort
        run_seq(2'd2, 32'h20202020, 1'b0, lat, runs, errs, s0, s1, s2);
        check("l2_lat",  lat, 13);
        check("l2_q",    q_out, 32'h22222222);
        check("l2_runs", runs, 2);
        check("l2_s1",   s1, ST_MIX2);
        tick();

        // spurious valid in IDLE, then start+valid during SETUP
        valid_force = 1'b1;
        tick();
        valid_force = 1'b0;
        check("idle_valid_busy", busy, 0);
        run_seq(2'd3, 32'h10101010, 1'b1, lat, runs, errs, s0, s1, s2);
        check("inj_lat",  lat, 19);
        check("inj_q",    q_out, 32'h13131313);
        check("inj_runs", runs, 3);
        check("inj_s2",   s2, ST_MIX3);
        tick();

`ifdef MIX_SEQ_TIMEOUT_EN
        // no valid at all: err after the 8th RUN cycle
        model_en = 1'b0;
        run_seq(2'd1, 32'h05050505, 1'b0, lat, runs, errs, s0, s1, s2);
        check("to_no_done", done, 0);
        check("to_errs",    errs, 1);
        check("to_busy",    busy, 0);
        check("to_run",     mix_run, 0);
        check("to_q",       q_out, 32'h13131313);
        tick();
        // valid on the expiry cycle completes normally
        model_en = 1'b1;
        model_v  = 8;
        run_seq(2'd1, 32'h05050505, 1'b0, lat, runs, errs, s0, s1, s2);
        check("to_edge_lat",  lat, 10);
        check("to_edge_err",  errs, 0);
        check("to_edge_q",    q_out, 32'h06060606);
        model_v = 5;
        tick();
`endif

        // reset in the middle of a run
        layer_num = 2'd3; d_in = 32'h44444444; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        check("mid_run_active", mix_run, 1);
        rst_n = 1'b0;
        #1;
        check("mrst_busy",  busy, 0);
        check("mrst_run",   mix_run, 0);
        check("mrst_state", mix_state, ST_MIX1);
        check("mrst_q",     q_out, 0);
        check("mrst_d",     mix_d, 0);
        check("mrst_done",  done, 0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
